// File: rtl/spike_pkg.sv
// Shared types and default widths for the spike event logging path.
package spike_pkg;

  localparam int unsigned SPIKE_DATA_W = 12;
  localparam int unsigned SPIKE_TS_W   = 16;
  localparam int unsigned SPIKE_DUR_W  = 8;

  typedef enum logic {IDLE, ACTIVE} ev_state_t;

  typedef struct packed {
    logic        [SPIKE_TS_W-1:0]   ts;
    logic        [SPIKE_DUR_W-1:0]  dur;
    logic signed [SPIKE_DATA_W-1:0] peak;
  } spike_event_t;

endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is only taken when a pop
// frees a slot in the same cycle.
module spike_event_fifo
  import spike_pkg::*;
#(
  parameter int unsigned WIDTH = $bits(spike_event_t),
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Once drained, the output keeps showing the record that was popped last.
  assign dout = empty ? last : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      last   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        last   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spike_event_logger.sv
// Turns spike pulses into {start timestamp, duration, peak} records, buffers
// them for a valid/ready reader and keeps overflow and event statistics.
module spike_event_logger
  import spike_pkg::*;
#(
  parameter int unsigned DATA_W = SPIKE_DATA_W,
  parameter int unsigned TS_W   = SPIKE_TS_W,
  parameter int unsigned DUR_W  = SPIKE_DUR_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     spike,
  input  logic signed [DATA_W-1:0] q,
  input  logic                     clr,
  input  logic                     ev_ready,
  output logic                     ev_valid,
  output logic        [TS_W-1:0]   ev_ts,
  output logic        [DUR_W-1:0]  ev_dur,
  output logic signed [DATA_W-1:0] ev_peak,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic        [CNT_W-1:0]  ev_count,
  output logic        [CNT_W-1:0]  drop_count
);

  typedef struct packed {
    logic        [TS_W-1:0]   ts;
    logic        [DUR_W-1:0]  dur;
    logic signed [DATA_W-1:0] peak;
  } rec_t;

  ev_state_t                 state, state_n;
  logic        [TS_W-1:0]    ts;
  logic        [TS_W-1:0]    start_ts, start_ts_n;
  logic        [DUR_W-1:0]   dur, dur_n;
  logic signed [DATA_W-1:0]  peak, peak_n;
  logic                      push_req;
  logic                      pop;
  logic                      full;
  logic                      empty;
  logic                      drop;
  rec_t                      rec_in;
  rec_t                      rec_out;

  assign pop      = ev_valid && ev_ready;
  assign drop     = push_req && full && !pop;
  assign ev_valid = !empty;
  assign rec_in   = '{ts: start_ts, dur: dur, peak: peak};
  assign ev_ts    = rec_out.ts;
  assign ev_dur   = rec_out.dur;
  assign ev_peak  = rec_out.peak;

  always_comb begin
    state_n    = state;
    start_ts_n = start_ts;
    dur_n      = dur;
    peak_n     = peak;
    push_req   = 1'b0;
    case (state)
      IDLE: begin
        if (spike) begin
          state_n    = ACTIVE;
          start_ts_n = ts;
          dur_n      = DUR_W'(1);
          peak_n     = q;
        end
      end
      ACTIVE: begin
        if (spike) begin
          if (dur != '1) dur_n = dur + DUR_W'(1);
          if (q > peak)  peak_n = q;
        end else begin
          state_n  = IDLE;
          push_req = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ts       <= '0;
      start_ts <= '0;
      dur      <= '0;
      peak     <= '0;
    end else begin
      state    <= state_n;
      ts       <= ts + TS_W'(1);
      start_ts <= start_ts_n;
      dur      <= dur_n;
      peak     <= peak_n;
    end
  end

  // Dropped records still count as events; clr overrides any same-cycle update.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      overflow   <= 1'b0;
      ev_count   <= '0;
      drop_count <= '0;
    end else if (push_req) begin
      if (ev_count != '1) ev_count <= ev_count + CNT_W'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

  spike_event_fifo #(
    .WIDTH ($bits(rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   (rec_in),
    .dout  (rec_out),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_spike_event_logger.sv
// Directed and randomized bench for spike_event_logger against a queue-based
// model of pulses, records, FIFO capacity and statistics.
module tb_spike_event_logger;

  logic               clk = 1'b0;
  logic               rst;
  logic               spike;
  logic signed [11:0] q;
  logic               clr;
  logic               ev_ready;
  logic               ev_valid;
  logic        [15:0] ev_ts;
  logic        [7:0]  ev_dur;
  logic signed [11:0] ev_peak;
  logic        [3:0]  level;
  logic               overflow;
  logic        [15:0] ev_count;
  logic        [15:0] drop_count;

  spike_event_logger #(
    .DATA_W (12),
    .TS_W   (16),
    .DUR_W  (8),
    .DEPTH  (8),
    .CNT_W  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spike      (spike),
    .q          (q),
    .clr        (clr),
    .ev_ready   (ev_ready),
    .ev_valid   (ev_valid),
    .ev_ts      (ev_ts),
    .ev_dur     (ev_dur),
    .ev_peak    (ev_peak),
    .level      (level),
    .overflow   (overflow),
    .ev_count   (ev_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ts;
    int dur;
    int peak;
  } rec_t;

  int   checks   = 0;
  int   failures = 0;

  int   m_ts;
  bit   m_act;
  int   m_start;
  int   m_len;
  int   m_max;
  rec_t mq[$];
  bit   m_ovf;
  int   m_evc;
  int   m_drop;
  bit   m_zero;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("ev_valid", ev_valid, mq.size() != 0);
    chk("level", level, mq.size());
    chk("overflow", overflow, m_ovf);
    chk("ev_count", ev_count, m_evc);
    chk("drop_count", drop_count, m_drop);
    if (mq.size() != 0) begin
      chk("head_ts", ev_ts, mq[0].ts);
      chk("head_dur", ev_dur, mq[0].dur);
      chk("head_peak", ev_peak, mq[0].peak);
    end else if (m_zero) begin
      chk("rst_ts", ev_ts, 0);
      chk("rst_dur", ev_dur, 0);
      chk("rst_peak", ev_peak, 0);
    end
  endtask

  // Applies the current inputs to the model as if a clock edge occurred.
  task automatic model_edge();
    bit   do_pop;
    bit   do_push;
    rec_t r;
    if (rst) begin
      m_ts = 0; m_act = 0; mq.delete();
      m_ovf = 0; m_evc = 0; m_drop = 0; m_zero = 1;
    end else begin
      do_pop  = (mq.size() != 0) && ev_ready;
      do_push = 0;
      if (m_act) begin
        if (spike) begin
          m_len++;
          if (q > m_max) m_max = q;
        end else begin
          do_push = 1;
          r = '{m_start, (m_len > 255) ? 255 : m_len, m_max};
          m_act = 0;
        end
      end else if (spike) begin
        m_act = 1; m_start = m_ts; m_len = 1; m_max = q;
      end
      if (do_pop) void'(mq.pop_front());
      if (clr) begin
        m_ovf = 0; m_evc = 0; m_drop = 0;
      end
      if (do_push) begin
        if (!clr && m_evc < 65535) m_evc++;
        if (mq.size() < 8) begin
          mq.push_back(r);
          m_zero = 0;
        end else if (!clr) begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
      m_ts = (m_ts + 1) % 65536;
    end
  endtask

  task automatic step();
    compare_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse1(input int qv);
    spike = 1'b1; q = 12'(qv); step();
    spike = 1'b0; q = '0;      step();
  endtask

  int          qv[4] = '{5, 40, -3, 20};
  int unsigned guard;

  initial begin
    rst = 1'b1; spike = 1'b0; q = '0; clr = 1'b0; ev_ready = 1'b0;
    model_edge();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single pulse at cycles 10..13
    repeat (10) step();
    for (int unsigned i = 0; i < 4; i++) begin
      spike = 1'b1; q = 12'(qv[i]); step();
    end
    spike = 1'b0; q = '0;
    step();
    chk("single_valid", ev_valid, 1);
    chk("single_ts", ev_ts, 10);
    chk("single_dur", ev_dur, 4);
    chk("single_peak", ev_peak, 40);
    chk("single_count", ev_count, 1);
    ev_ready = 1'b1; step();

    // negative peak, back-to-back pulses
    spike = 1'b1; q = -12'sd100; step(); chk("b2b_lvl", level <= 1, 1);
    spike = 1'b1; q = -12'sd50;  step(); chk("b2b_lvl", level <= 1, 1);
    spike = 1'b0; q = '0;        step(); chk("b2b_lvl", level <= 1, 1);
    spike = 1'b1; q = -12'sd7;   step(); chk("b2b_lvl", level <= 1, 1);
    spike = 1'b0; q = '0;
    repeat (3) begin
      step(); chk("b2b_lvl", level <= 1, 1);
    end

    // overflow with nine records and no reader
    clr = 1'b1; ev_ready = 1'b0; step(); clr = 1'b0;
    for (int unsigned i = 0; i < 9; i++) pulse1(int'(i) * 11 - 40);
    step();
    chk("ovf_level", level, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_count, 1);
    chk("ovf_count", ev_count, 9);

    // full FIFO, push coincides with pop
    clr = 1'b1; step(); clr = 1'b0;
    spike = 1'b1; q = 12'sd77; step();
    spike = 1'b0; q = '0; ev_ready = 1'b1; step();
    ev_ready = 1'b0;
    chk("fullpop_level", level, 8);
    chk("fullpop_ovf", overflow, 0);
    chk("fullpop_drop", drop_count, 0);
    ev_ready = 1'b1;
    repeat (10) step();

    // randomized traffic
    for (int unsigned seg = 0; seg < 2; seg++) begin
      repeat (1500) begin
        if ($urandom_range(0, 3) == 0) spike = ~spike;
        q        = 12'($urandom);
        ev_ready = ($urandom_range(0, 9) < ((seg == 0) ? 2 : 8));
        clr      = ($urandom_range(0, 99) == 0);
        step();
      end
    end

    // long pulse across the timestamp wrap
    spike = 1'b0; clr = 1'b0; ev_ready = 1'b1; q = '0;
    guard = 0;
    while (m_ts != 65530 && guard < 70000) begin
      step();
      guard++;
    end
    ev_ready = 1'b0;
    repeat (300) begin
      spike = 1'b1; q = 12'($urandom); step();
    end
    spike = 1'b0; q = '0;
    step();
    chk("wrap_valid", ev_valid, 1);
    chk("wrap_ts", ev_ts, 65530);
    chk("wrap_dur", ev_dur, 255);

    // reset in the third cycle of a pulse
    spike = 1'b1; q = 12'sd9; step(); step();
    rst = 1'b1; step();
    rst = 1'b0; spike = 1'b0; q = '0;
    repeat (4) step();
    chk("rst_valid", ev_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ev_ts", ev_ts, 0);
    chk("rst_ev_dur", ev_dur, 0);
    chk("rst_ev_peak", ev_peak, 0);
    chk("rst_count", ev_count, 0);
    chk("rst_ovf", overflow, 0);

    // pulse continuing right after reset starts at ts 0
    spike = 1'b1; q = 12'sd9; step(); step();
    rst = 1'b1; step();
    rst = 1'b0; q = 12'sd3; step();
    spike = 1'b0; q = '0; step();
    chk("postrst_ts", ev_ts, 0);
    chk("postrst_dur", ev_dur, 1);
    chk("postrst_peak", ev_peak, 3);

    // clr coincides with a drop
    ev_ready = 1'b0;
    for (int unsigned i = 0; i < 7; i++) pulse1(int'(i));
    spike = 1'b1; q = 12'sd1; step();
    spike = 1'b0; q = '0; clr = 1'b1; step();
    clr = 1'b0;
    chk("clrdrop_ovf", overflow, 0);
    chk("clrdrop_drop", drop_count, 0);
    chk("clrdrop_count", ev_count, 0);
    chk("clrdrop_level", level, 8);
    ev_ready = 1'b1;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
